// File: rtl/j68_useq.sv
// j68_useq: J68 micro-program sequencer; define J68_USEQ_STACK_CHECK_EN to trap return-stack over/underflow.
module j68_useq #(
    parameter logic [10:0] RESET_ADDR = 11'h000,
    parameter int STACK_DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        clocken,
    input  logic        stall,
    output logic        rden_a,
    output logic [10:0] address_a,
    input  logic [19:0] q_a,
    input  logic [31:0] cond,
    input  logic [10:0] disp_addr,
    input  logic        disp_vld,
    input  logic        loop_ld,
    input  logic [15:0] loop_val,
    output logic [19:0] uinstr,
    output logic        uinstr_vld,
    output logic [10:0] upc,
    output logic        seq_err
);
    localparam int AW = $clog2(STACK_DEPTH);
`ifdef J68_USEQ_STACK_CHECK_EN
    localparam int SW = AW + 1;
`else
    localparam int SW = AW;
`endif
    localparam logic [SW-1:0] ONE = SW'(1);
    typedef enum logic [1:0] {BOOT, RUN, DWAIT, HALTED} state_t;
    state_t state, state_nx;
    logic [10:0] pc, pc_inc, pc_nx;
    logic [SW-1:0] sp, sp_inc, sp_dec;
    logic [10:0] stack [STACK_DEPTH];
    logic [15:0] loop_cnt;
    logic [3:0] typ;
    logic adv, fetch, push, pop, dec, err, push_err, pop_err, taken;
`ifdef J68_USEQ_STACK_CHECK_EN
    assign push_err = sp == SW'(STACK_DEPTH);
    assign pop_err = sp == '0;
`else
    assign push_err = 1'b0;
    assign pop_err = 1'b0;
`endif
    assign adv = clocken & ~stall;
    assign typ = q_a[19:16];
    assign pc_inc = pc + 11'd1;
    assign sp_inc = sp + ONE;
    assign sp_dec = sp - ONE;
    // BT is 4'b1011 and BF is 4'b1100, so bit 2 selects the inverted sense
    assign taken = cond[q_a[15:11]] ^ typ[2];
    always_comb begin
        state_nx = state;
        pc_nx = pc_inc;
        fetch = 1'b0;
        push = 1'b0;
        pop = 1'b0;
        dec = 1'b0;
        err = 1'b0;
        case (state)
            BOOT: begin
                pc_nx = RESET_ADDR;
                fetch = 1'b1;
                state_nx = RUN;
            end
            RUN: begin
                fetch = 1'b1;
                case (typ)
                    4'h8: pc_nx = q_a[10:0];
                    4'h9: begin
                        pc_nx = q_a[10:0];
                        push = ~push_err;
                        err = push_err;
                    end
                    4'hA: begin
                        pc_nx = stack[sp_dec[AW-1:0]];
                        pop = ~pop_err;
                        err = pop_err;
                    end
                    4'hB, 4'hC: pc_nx = taken ? q_a[10:0] : pc_inc;
                    4'hD: begin
                        pc_nx = disp_addr;
                        fetch = disp_vld;
                        state_nx = disp_vld ? RUN : DWAIT;
                    end
                    4'hE: begin
                        dec = ~loop_ld & (loop_cnt != '0);
                        pc_nx = dec ? q_a[10:0] : pc_inc;
                    end
                    4'hF: begin
                        fetch = 1'b0;
                        state_nx = HALTED;
                    end
                    default: ;
                endcase
                if (err) begin
                    fetch = 1'b0;
                    state_nx = HALTED;
                end
            end
            DWAIT: begin
                pc_nx = disp_addr;
                fetch = disp_vld;
                state_nx = disp_vld ? RUN : DWAIT;
            end
            default: pc_nx = pc;
        endcase
    end
    assign rden_a = adv & fetch;
    assign address_a = pc_nx;
    assign uinstr = q_a;
    assign upc = pc;
    assign uinstr_vld = adv & (state == RUN) & ~typ[3];
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= BOOT;
            pc <= RESET_ADDR;
            sp <= '0;
            loop_cnt <= '0;
            seq_err <= 1'b0;
        end else if (adv) begin
            state <= state_nx;
            if (fetch)
                pc <= pc_nx;
            if (push)
                sp <= sp_inc;
            else if (pop)
                sp <= sp_dec;
            if (loop_ld)
                loop_cnt <= loop_val;
            else if (dec)
                loop_cnt <= loop_cnt - 16'd1;
            seq_err <= seq_err | err;
        end
    end
    always_ff @(posedge clock) begin
        if (adv && push)
            stack[sp[AW-1:0]] <= pc_inc;
    end
endmodule

// File: tb/tb_j68_useq.sv
// tb_j68_useq: scoreboard bench for the J68 micro-sequencer fetch and execute streams.
module tb_j68_useq;
    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        clocken = 1'b1;
    logic        stall = 1'b0;
    logic        rden_a;
    logic [10:0] address_a;
    logic [19:0] q_a = '0;
    logic [31:0] cond = '0;
    logic [10:0] disp_addr = '0;
    logic        disp_vld = 1'b0;
    logic        loop_ld = 1'b0;
    logic [15:0] loop_val = '0;
    logic [19:0] uinstr;
    logic        uinstr_vld;
    logic [10:0] upc;
    logic        seq_err;
    logic [19:0] mem [2048];
    logic [10:0] fq [$];
    logic [30:0] xq [$];
    int n_cmp = 0;
    int n_err = 0;

    j68_useq dut (
        .clock(clock), .reset_n(reset_n), .clocken(clocken), .stall(stall),
        .rden_a(rden_a), .address_a(address_a), .q_a(q_a), .cond(cond),
        .disp_addr(disp_addr), .disp_vld(disp_vld), .loop_ld(loop_ld), .loop_val(loop_val),
        .uinstr(uinstr), .uinstr_vld(uinstr_vld), .upc(upc), .seq_err(seq_err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) if (rden_a) q_a <= mem[address_a];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clock) if (reset_n) begin
        if (rden_a) begin
            if (fq.size() == 0)
                check("unexpected_fetch", 32'(address_a), 32'hFFFFFFFF);
            else
                check("fetch", 32'(address_a), 32'(fq.pop_front()));
        end
        if (uinstr_vld) begin
            if (xq.size() == 0)
                check("unexpected_exec", 32'({upc, uinstr}), 32'hFFFFFFFF);
            else
                check("exec", 32'({upc, uinstr}), 32'(xq.pop_front()));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic boot();
        reset_n = 1'b0;
        stall = 1'b0;
        clocken = 1'b1;
        disp_vld = 1'b0;
        disp_addr = 11'h155;
        loop_ld = 1'b0;
        loop_val = '0;
        cond = '0;
        fq.delete();
        xq.delete();
        foreach (mem[i]) mem[i] = 20'hF0000;
        cyc(1);
    endtask

    task automatic drain(input string tag);
        check({tag, "_fetch_left"}, fq.size(), 0);
        check({tag, "_exec_left"}, xq.size(), 0);
        cyc(4);
        fq.delete();
        xq.delete();
    endtask

    initial begin
        logic tk;
        boot();
        check("rst_upc", 32'(upc), 32'h0);
        check("rst_vld", 32'(uinstr_vld), 32'h0);
        check("rst_err", 32'(seq_err), 32'h0);
        check("rst_addr", 32'(address_a), 32'h0);

        mem[0] = 20'h01234;
        mem[1] = 20'h80010;
        fq = '{11'h000, 11'h001, 11'h010};
        xq.push_back({11'h000, 20'h01234});
        reset_n = 1'b1;
        cyc(3);
        drain("basic");

        boot();
        for (int i = 0; i < 5; i++) begin
            mem[i] = 20'h10000 | 20'(i);
            xq.push_back({11'(i), 20'h10000 | 20'(i)});
        end
        for (int i = 0; i < 6; i++) fq.push_back(11'(i));
        mem[5] = 20'h90100;
        mem[6] = 20'h90100;
        mem[11'h100] = 20'hA0000;
        fq.push_back(11'h100);
        fq.push_back(11'h006);
        fq.push_back(11'h100);
        fq.push_back(11'h007);
        reset_n = 1'b1;
        cyc(10);
        drain("jsr_rts");

        for (int k = 0; k < 4; k++) begin
            boot();
            mem[0] = 20'h80020;
            mem[11'h020] = (k >= 2) ? 20'hC1840 : 20'hB1840;
            cond = $urandom;
            cond[3] = k[0];
            tk = (k >= 2) ? ~cond[3] : cond[3];
            fq = '{11'h000, 11'h020, tk ? 11'h040 : 11'h021};
            reset_n = 1'b1;
            cyc(3);
            drain((k >= 2) ? "bf" : "bt");
        end

        boot();
        mem[0] = 20'h80030;
        mem[11'h030] = 20'h30030;
        mem[11'h031] = 20'h70031;
        mem[11'h032] = 20'hE0030;
        fq.push_back(11'h000);
        for (int it = 0; it < 4; it++) begin
            fq.push_back(11'h030);
            fq.push_back(11'h031);
            fq.push_back(11'h032);
            xq.push_back({11'h030, 20'h30030});
            xq.push_back({11'h031, 20'h70031});
        end
        fq.push_back(11'h033);
        loop_ld = 1'b1;
        loop_val = 16'd3;
        reset_n = 1'b1;
        cyc(1);
        loop_ld = 1'b0;
        cyc(13);
        drain("loop");

        boot();
        mem[0] = 20'h00001;
        mem[1] = 20'hE0000;
        fq = '{11'h000, 11'h001, 11'h002};
        xq.push_back({11'h000, 20'h00001});
        loop_ld = 1'b1;
        loop_val = 16'd5;
        reset_n = 1'b1;
        cyc(1);
        loop_ld = 1'b0;
        cyc(1);
        loop_ld = 1'b1;
        loop_val = 16'd1;
        cyc(1);
        loop_ld = 1'b0;
        drain("loop_ld_prio");

        boot();
        mem[0] = 20'hD0000;
        mem[11'h2A0] = 20'h00777;
        fq = '{11'h000, 11'h2A0, 11'h2A1};
        xq.push_back({11'h2A0, 20'h00777});
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            check("dwait_rden", 32'(rden_a), 32'h0);
            check("dwait_vld", 32'(uinstr_vld), 32'h0);
        end
        cyc(1);
        disp_vld = 1'b1;
        disp_addr = 11'h2A0;
        cyc(1);
        disp_vld = 1'b0;
        disp_addr = 11'h155;
        cyc(2);
        drain("disp");

        boot();
        for (int i = 0; i < 6; i++) begin
            mem[i] = 20'h2A000 | 20'(i);
            xq.push_back({11'(i), 20'h2A000 | 20'(i)});
        end
        for (int i = 0; i < 7; i++) fq.push_back(11'(i));
        reset_n = 1'b1;
        cyc(3);
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("stall_upc", 32'(upc), 32'h2);
            check("stall_uinstr", 32'(uinstr), 32'h2A002);
            check("stall_rden", 32'(rden_a), 32'h0);
            check("stall_vld", 32'(uinstr_vld), 32'h0);
            cyc(1);
        end
        stall = 1'b0;
        cyc(1);
        clocken = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("clken_upc", 32'(upc), 32'h3);
            check("clken_uinstr", 32'(uinstr), 32'h2A003);
            check("clken_rden", 32'(rden_a), 32'h0);
            check("clken_vld", 32'(uinstr_vld), 32'h0);
            cyc(1);
        end
        clocken = 1'b1;
        cyc(3);
        drain("stall_clken");

        boot();
        for (int i = 0; i < 9; i++) begin
            mem[i] = 20'h90000 | 20'(i + 1);
            fq.push_back(11'(i));
        end
`ifdef J68_USEQ_STACK_CHECK_EN
        reset_n = 1'b1;
        cyc(11);
        check("ovf_err", 32'(seq_err), 32'h1);
        check("ovf_rden", 32'(rden_a), 32'h0);
        drain("stack_ovf");
        check("ovf_err_sticky", 32'(seq_err), 32'h1);
        boot();
        check("err_cleared", 32'(seq_err), 32'h0);
        mem[0] = 20'hA0000;
        fq = '{11'h000};
        reset_n = 1'b1;
        cyc(3);
        check("unf_err", 32'(seq_err), 32'h1);
        check("unf_rden", 32'(rden_a), 32'h0);
        drain("stack_unf");
`else
        fq.push_back(11'h009);
        reset_n = 1'b1;
        cyc(12);
        check("wrap_err", 32'(seq_err), 32'h0);
        drain("stack_wrap");
`endif

        boot();
        mem[0] = 20'h80003;
        mem[3] = 20'hD0000;
        fq = '{11'h000, 11'h003};
        reset_n = 1'b1;
        cyc(4);
        check("dwait_fetch_left", fq.size(), 0);
        check("dwait_upc", 32'(upc), 32'h3);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_addr", 32'(address_a), 32'h0);
        check("arst_upc", 32'(upc), 32'h0);
        check("arst_vld", 32'(uinstr_vld), 32'h0);
        mem[0] = 20'h00ABC;
        fq = '{11'h000, 11'h001};
        xq.push_back({11'h000, 20'h00ABC});
        cyc(1);
        reset_n = 1'b1;
        cyc(2);
        drain("rst_dwait");

        boot();
        mem[0] = 20'hC07FF;
        mem[11'h7FF] = 20'h05555;
        fq = '{11'h000, 11'h7FF, 11'h000, 11'h001};
        xq.push_back({11'h7FF, 20'h05555});
        reset_n = 1'b1;
        cyc(2);
        cond = 32'h1;
        cyc(3);
        drain("pc_wrap");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
